sha3_theta_apply: RTL and testbench

- Consumer side of the theta-elt interface: applies theta to the 5x5 state.
- Captures the same five state rows on the same `sample` strobe as the theta-elt evaluator.
- Delays the 25 lanes so they meet the five elts `ielt[x]` when those become valid, then XORs `ielt[x]` into every lane of column x.
- Registers the result with a valid strobe for the next round stage (rho/pi).

---
 rtl/sha3_pkg.sv | 11 +
 rtl/sha3_state_delay.sv | 37 +++
 rtl/sha3_theta_apply.sv | 79 +++++++
 tb/tb_sha3_theta_apply.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] types and constants for the round datapath.
package sha3_pkg;
   localparam int LANE_W            = 64;
   localparam int NUM_ROWS          = 5;
   localparam int NUM_COLS          = 5;
   localparam int THETA_ELT_LATENCY = 3;

   typedef logic [LANE_W-1:0]         lane_t;
   typedef lane_t [NUM_COLS-1:0]      row_t;
   typedef row_t  [NUM_ROWS-1:0]      state_t;
endpackage

// File: rtl/sha3_state_delay.sv
// Depth-N alignment pipe for a full 5x5 state plus its valid bit.
// Stage 0 loads only on `load`; later stages shift every cycle.
module sha3_state_delay
   import sha3_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  state_t din,
   output state_t dout,
   output logic   dvld
);

   state_t           stg_q [DEPTH];
   logic [DEPTH-1:0] vld_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= load;
         for (int k = 1; k < DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   // Data is qualified by vld_pipe, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) stg_q[0] <= din;
      for (int k = 1; k < DEPTH; k++) stg_q[k] <= stg_q[k-1];
   end

   assign dout = stg_q[DEPTH-1];
   assign dvld = vld_pipe[DEPTH-1];

endmodule

// File: rtl/sha3_theta_apply.sv
// Theta apply: aligns the captured state with the evaluator's D[x] and
// XORs D[x] into every lane of column x, registering the result.
module sha3_theta_apply
   import sha3_pkg::*;
#(
   parameter int ELT_LATENCY = THETA_ELT_LATENCY
) (
   input  logic clk,
   input  logic rst_n,
   input  row_t isa,
   input  row_t isb,
   input  row_t isc,
   input  row_t isd,
   input  row_t ise,
   input  logic sample,
   input  row_t ielt,
   output row_t osa,
   output row_t osb,
   output row_t osc,
   output row_t osd,
   output row_t ose,
   output logic ovalid,
   output logic busy
);

   state_t     st_in, st_dl, out_q;
   logic       dl_vld;
   logic [3:0] cnt_q, cnt_nxt;

   assign st_in = {ise, isd, isc, isb, isa};

   sha3_state_delay #(.DEPTH(ELT_LATENCY)) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sample),
      .din   (st_in),
      .dout  (st_dl),
      .dvld  (dl_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         ovalid <= 1'b0;
      end else begin
         ovalid <= dl_vld;
         if (dl_vld) begin
            for (int y = 0; y < NUM_ROWS; y++)
               for (int x = 0; x < NUM_COLS; x++)
                  out_q[y][x] <= st_dl[y][x] ^ ielt[x];
         end
      end
   end

   // Capture and retire in the same cycle cancel out.
   always_comb begin
      cnt_nxt = cnt_q;
      if (sample && !ovalid)      cnt_nxt = cnt_q + 4'd1;
      else if (!sample && ovalid) cnt_nxt = cnt_q - 4'd1;
   end

   // busy follows the next count so it rises the cycle after capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         busy  <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         busy  <= (cnt_nxt != 4'd0);
      end
   end

   assign osa = out_q[0];
   assign osb = out_q[1];
   assign osc = out_q[2];
   assign osd = out_q[3];
   assign ose = out_q[4];

endmodule

// File: tb/tb_sha3_theta_apply.sv
// Directed bench for sha3_theta_apply (default latency plus a latency-1 build).
module tb_sha3_theta_apply;
   import sha3_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   sample = 1'b0;
   state_t st = '0;
   row_t   elt = '0;

   row_t osa, osb, osc, osd, ose;
   logic ovalid, busy;
   row_t osa1, osb1, osc1, osd1, ose1;
   logic ovalid1, busy1;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sha3_theta_apply dut (
      .clk(clk), .rst_n(rst_n),
      .isa(st[0]), .isb(st[1]), .isc(st[2]), .isd(st[3]), .ise(st[4]),
      .sample(sample), .ielt(elt),
      .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
      .ovalid(ovalid), .busy(busy)
   );

   sha3_theta_apply #(.ELT_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .isa(st[0]), .isb(st[1]), .isc(st[2]), .isd(st[3]), .ise(st[4]),
      .sample(sample), .ielt(elt),
      .osa(osa1), .osb(osb1), .osc(osc1), .osd(osd1), .ose(ose1),
      .ovalid(ovalid1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic state_t outs();
      return {ose, osd, osc, osb, osa};
   endfunction

   // Single sample through the latency-3 instance; checks the whole timeline.
   task automatic run_one(input string tag, input state_t s, input row_t d, input state_t exp);
      state_t o;
      st = s; sample = 1'b1; elt = '0;
      step();                                    // T+1
      sample = 1'b0; st = '0;
      chk({tag, ".busy1"}, 64'(busy), 64'd1);
      chk({tag, ".nov1"}, 64'(ovalid), 64'd0);
      step(); step();                            // T+3
      elt = d;
      chk({tag, ".nov3"}, 64'(ovalid), 64'd0);
      step();                                    // T+4
      elt = '0;
      chk({tag, ".ovalid"}, 64'(ovalid), 64'd1);
      chk({tag, ".busy4"}, 64'(busy), 64'd1);
      o = outs();
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            chk($sformatf("%s.o[%0d][%0d]", tag, y, x), o[y][x], exp[y][x]);
      step();                                    // T+5
      chk({tag, ".ovdrop"}, 64'(ovalid), 64'd0);
      chk({tag, ".busydrop"}, 64'(busy), 64'd0);
   endtask

   initial begin
      state_t s, e;
      row_t   d;
      int     peak;
      bit     seen;

      #12;
      chk("rst.ovalid", 64'(ovalid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.osa0", osa[0], 64'd0);
      chk("rst.ose4", ose[4], 64'd0);
      rst_n = 1'b1;
      step();

      // Zero state, zero elts.
      run_one("zero", '0, '0, '0);

      // isa[0]=1, D[1]=1, D[4]=2.
      s = '0; s[0][0] = 64'd1;
      d = '0; d[1] = 64'd1; d[4] = 64'd2;
      e = '0;
      for (int y = 0; y < 5; y++) begin
         e[y][1] = 64'd1;
         e[y][4] = 64'd2;
      end
      e[0][0] = 64'd1;
      run_one("single", s, d, e);

      // All ones: every column has odd parity, so every D[x] is zero.
      s = '1;
      run_one("ones", s, '0, s);

      // Three back-to-back samples; sample c (0..2) carries isa[0]=c+1,
      // its elt D[0]=16*(c+1) arrives at c+3, output at c+4.
      peak = 0;
      for (int c = 0; c < 9; c++) begin
         sample = (c < 3);
         st = '0; st[0][0] = 64'(c + 1);
         elt = '0;
         if (c >= 3 && c < 6) elt[0] = 64'(16 * (c - 2));
         chk($sformatf("b2b.ov%0d", c), 64'(ovalid), 64'(c >= 4 && c <= 6));
         chk($sformatf("b2b.busy%0d", c), 64'(busy), 64'(c >= 1 && c <= 6));
         if (c >= 4 && c <= 6)
            chk($sformatf("b2b.d%0d", c), osa[0], 64'((c - 3) ^ (16 * (c - 3))));
         if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
         step();
      end
      sample = 1'b0; st = '0; elt = '0;
      chk("b2b.peak", 64'(peak), 64'd3);

      // Reset two cycles after a sample drops the state.
      st = '0; st[2][3] = 64'hABCD; sample = 1'b1;
      step();
      sample = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.busy", 64'(busy), 64'd0);
      chk("mrst.ovalid", 64'(ovalid), 64'd0);
      #3 rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (ovalid) seen = 1'b1;
      end
      chk("mrst.noghost", 64'(seen), 64'd0);
      s = '0; s[3][2] = 64'h55;
      d = '0; d[2] = 64'hF0;
      e = '0;
      for (int y = 0; y < 5; y++) e[y][2] = 64'hF0;
      e[3][2] = 64'hA5;
      run_one("post", s, d, e);
      step(); step(); step();

      // Latency-1 build: ielt at T+1, ovalid at T+2.
      st = '0; st[1][2] = 64'd5; sample = 1'b1; elt = '0;
      step();                                    // T+1
      sample = 1'b0; st = '0;
      elt = '0; elt[2] = 64'd3;
      chk("l1.nov1", 64'(ovalid1), 64'd0);
      chk("l1.busy1", 64'(busy1), 64'd1);
      step();                                    // T+2
      elt = '0;
      chk("l1.ovalid", 64'(ovalid1), 64'd1);
      chk("l1.osb2", osb1[2], 64'd6);
      chk("l1.osa2", osa1[2], 64'd3);
      chk("l1.osb0", osb1[0], 64'd0);
      step();
      chk("l1.ovdrop", 64'(ovalid1), 64'd0);
      chk("l1.busydrop", 64'(busy1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
